// File: rtl/exec_unit_pipe.sv
// Registered execute stage with valid/ready handshake, iterative shift-add multiplier and branch target.
// Define EXEC_OVERFLOW_FLAG_EN to add the Overflow output and the double-width multiply accumulator.
module exec_unit_pipe #(
   parameter int WIDTH     = 32,
   parameter int IMM_W     = 16,
   parameter int TGT_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pc_inc,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   input  logic [IMM_W-1:0] imm,
   input  logic             ExtOp,
   input  logic             ALUSrc,
   input  logic [2:0]       ALUctr,
   input  logic             MulOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUout,
   output logic             Zero,
   output logic [WIDTH-1:0] Target
`ifdef EXEC_OVERFLOW_FLAG_EN
   ,
   output logic             Overflow
`endif
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_e;

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef EXEC_OVERFLOW_FLAG_EN
   localparam int ACC_W = 2 * WIDTH;
`else
   localparam int ACC_W = WIDTH;
`endif

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_SLTU = 3'b110;
   localparam logic [2:0] OP_NOR  = 3'b111;

   state_e             state_q;
   logic               out_valid_q;
   logic [WIDTH-1:0]   alu_q;
   logic               zero_q;
   logic [WIDTH-1:0]   target_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [ACC_W-1:0]   acc_d;

   logic               accept;
   logic [WIDTH-1:0]   ext_imm;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH-1:0]   target_calc;

   assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   assign ext_imm     = ExtOp ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm}
                              : {{(WIDTH-IMM_W){1'b0}}, imm};
   assign opb         = ALUSrc ? ext_imm : busB;
   assign sum         = busA + opb;
   assign diff        = busA - opb;
   assign target_calc = (ext_imm << TGT_SHIFT) + pc_inc;

   // One shift-add step: accumulate the shifted multiplicand when the current multiplier bit is set.
   assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      // NOTE: assign a default before the case so every path drives alu_res and no latch is inferred.
      alu_res = '0;
      case (ALUctr)
         OP_ADD:  alu_res = sum;
         OP_SUB:  alu_res = diff;
         OP_AND:  alu_res = busA & opb;
         OP_OR:   alu_res = busA | opb;
         OP_XOR:  alu_res = busA ^ opb;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(busA) < $signed(opb))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (busA < opb)};
         OP_NOR:  alu_res = ~(busA | opb);
         default: alu_res = '0;
      endcase
   end

`ifdef EXEC_OVERFLOW_FLAG_EN
   logic alu_ovf;
   logic mul_ovf;
   logic ovf_q;

   always_comb begin
      alu_ovf = 1'b0;
      if (ALUctr == OP_ADD)
         alu_ovf = (busA[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != busA[WIDTH-1]);
      else if (ALUctr == OP_SUB)
         alu_ovf = (busA[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != busA[WIDTH-1]);
   end

   assign mul_ovf  = |acc_d[ACC_W-1:WIDTH];
   assign Overflow = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
         if (accept && !MulOp)
            ovf_q <= alu_ovf;
      end else if (cnt_q == CNT_W'(WIDTH-1)) begin
         ovf_q <= mul_ovf;
      end
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         alu_q       <= '0;
         zero_q      <= 1'b0;
         target_q    <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  target_q <= target_calc;
                  if (MulOp) begin
                     out_valid_q <= 1'b0;
                     acc_q       <= '0;
                     mcand_q     <= ACC_W'(busA);
                     mplier_q    <= opb;
                     cnt_q       <= '0;
                     state_q     <= S_MUL;
                  end else begin
                     out_valid_q <= 1'b1;
                     alu_q       <= alu_res;
                     zero_q      <= (alu_res == '0);
                  end
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  alu_q       <= acc_d[WIDTH-1:0];
                  zero_q      <= (acc_d[WIDTH-1:0] == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign ALUout    = alu_q;
   assign Zero      = zero_q;
   assign Target    = target_q;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed self-checking bench for exec_unit_pipe; define EXEC_OVERFLOW_FLAG_EN to also check Overflow.
module tb_exec_unit_pipe;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] SUB  = 3'b001;
   localparam logic [2:0] AND_ = 3'b010;
   localparam logic [2:0] OR_  = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100;
   localparam logic [2:0] SLT  = 3'b101;
   localparam logic [2:0] SLTU = 3'b110;
   localparam logic [2:0] NOR_ = 3'b111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_inc;
   logic [31:0] busA;
   logic [31:0] busB;
   logic [15:0] imm;
   logic        ExtOp;
   logic        ALUSrc;
   logic [2:0]  ALUctr;
   logic        MulOp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUout;
   logic        Zero;
   logic [31:0] Target;
`ifdef EXEC_OVERFLOW_FLAG_EN
   logic        Overflow;
`endif

   int n_pass  = 0;
   int n_total = 0;

   exec_unit_pipe #(.WIDTH(32), .IMM_W(16), .TGT_SHIFT(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pc_inc    (pc_inc),
      .busA      (busA),
      .busB      (busB),
      .imm       (imm),
      .ExtOp     (ExtOp),
      .ALUSrc    (ALUSrc),
      .ALUctr    (ALUctr),
      .MulOp     (MulOp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUout    (ALUout),
      .Zero      (Zero),
      .Target    (Target)
`ifdef EXEC_OVERFLOW_FLAG_EN
      ,
      .Overflow  (Overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctr,
                        input logic mul, input logic src, input logic ext,
                        input logic [15:0] im, input logic [31:0] pc);
      busA     = a;
      busB     = b;
      ALUctr   = ctr;
      MulOp    = mul;
      ALUSrc   = src;
      ExtOp    = ext;
      imm      = im;
      pc_inc   = pc;
      in_valid = 1'b1;
   endtask

   task automatic drain();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(32'd0, 32'd0, ADD, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      in_valid = 1'b0;
      #12;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_total++; if (ALUout !== 32'd0) $display("FAIL reset_aluout: got %h expected 0", ALUout); else n_pass++;
      n_total++; if (Zero !== 1'b0) $display("FAIL reset_zero: got %b expected 0", Zero); else n_pass++;
      n_total++; if (Target !== 32'd0) $display("FAIL reset_target: got %h expected 0", Target); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      @(negedge clk);
      drive(32'd5, 32'd7, ADD, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL add_in_ready: got %b expected 1", in_ready); else n_pass++;
      tick();
      n_total++; if (ALUout !== 32'd12) $display("FAIL add_result: got %h expected 0000000c", ALUout); else n_pass++;
      n_total++; if (Zero !== 1'b0) $display("FAIL add_zero: got %b expected 0", Zero); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL add_out_valid: got %b expected 1", out_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [7]   = '{32'd3, 32'd0, 32'h0000F0F0, 32'h0000F000, 32'h000000FF, 32'd0, 32'hFFFFFFFF};
      logic [31:0] vb [7]   = '{32'd4, 32'd1, 32'h00003C3C, 32'h0000000F, 32'h0000000F, 32'd0, 32'd1};
      logic [2:0]  vc [7]   = '{ADD, SUB, AND_, OR_, XOR_, NOR_, ADD};
      logic [31:0] vexp [7] = '{32'd7, 32'hFFFFFFFF, 32'h00003030, 32'h0000F00F, 32'h000000F0, 32'hFFFFFFFF, 32'd0};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(va[i], vb[i], vc[i], 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
         tick();
         n_total++; if (ALUout !== vexp[i]) $display("FAIL b2b_result[%0d]: got %h expected %h", i, ALUout, vexp[i]); else n_pass++;
         n_total++; if (Zero !== (vexp[i] == 32'd0)) $display("FAIL b2b_zero[%0d]: got %b expected %b", i, Zero, (vexp[i] == 32'd0)); else n_pass++;
         n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); else n_pass++;
      end
      drain();
      n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", out_valid); else n_pass++;
   endtask

   task automatic test_target();
      logic        vext [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        vsrc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [2:0]  vc   [5] = '{SUB, SUB, ADD, ADD, ADD};
      logic [31:0] va   [5] = '{32'd9, 32'd9, 32'd9, 32'd0, 32'd0};
      logic [15:0] vim  [5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000};
      logic [31:0] vtgt [5] = '{32'h000000FC, 32'h000400FC, 32'h000000FC, 32'h00020100, 32'hFFFE0100};
      logic [31:0] vexp [5] = '{32'd0, 32'd0, 32'd8, 32'h00008000, 32'hFFFF8000};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(va[i], 32'd9, vc[i], 1'b0, vsrc[i], vext[i], vim[i], 32'h00000100);
         tick();
         n_total++; if (Target !== vtgt[i]) $display("FAIL target[%0d]: got %h expected %h", i, Target, vtgt[i]); else n_pass++;
         n_total++; if (ALUout !== vexp[i]) $display("FAIL target_alu[%0d]: got %h expected %h", i, ALUout, vexp[i]); else n_pass++;
         n_total++; if (Zero !== (vexp[i] == 32'd0)) $display("FAIL target_zero[%0d]: got %b expected %b", i, Zero, (vexp[i] == 32'd0)); else n_pass++;
      end
      drain();
   endtask

   // Starts a multiply, keeps a decoy add bundle on the inputs during MUL and reports timing.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          output int edge_no, output int lo_cnt);
      @(negedge clk);
      drive(a, b, ADD, 1'b1, 1'b0, 1'b0, 16'h0004, 32'h00000200);
      tick();
      edge_no = 1;
      lo_cnt  = 0;
      drive(32'd1, 32'd1, ADD, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h00000000);
      if (in_ready === 1'b0) lo_cnt++;
      while (out_valid !== 1'b1 && edge_no < 40) begin
         tick();
         edge_no++;
         if (in_ready === 1'b0) lo_cnt++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_mul();
      logic [31:0] va   [3] = '{32'd7, 32'hFFFFFFFF, 32'h00010000};
      logic [31:0] vb   [3] = '{32'd6, 32'd2, 32'h00010000};
      logic [31:0] vexp [3] = '{32'd42, 32'hFFFFFFFE, 32'd0};
`ifdef EXEC_OVERFLOW_FLAG_EN
      logic        vovf [3] = '{1'b0, 1'b1, 1'b1};
`endif
      int edge_no;
      int lo_cnt;
      for (int i = 0; i < 3; i++) begin
         run_mul(va[i], vb[i], edge_no, lo_cnt);
         n_total++; if (edge_no !== 33) $display("FAIL mul_latency[%0d]: got edge %0d expected 33", i, edge_no); else n_pass++;
         n_total++; if (lo_cnt !== 32) $display("FAIL mul_stall[%0d]: got %0d cycles expected 32", i, lo_cnt); else n_pass++;
         n_total++; if (ALUout !== vexp[i]) $display("FAIL mul_result[%0d]: got %h expected %h", i, ALUout, vexp[i]); else n_pass++;
         n_total++; if (Zero !== (vexp[i] == 32'd0)) $display("FAIL mul_zero[%0d]: got %b expected %b", i, Zero, (vexp[i] == 32'd0)); else n_pass++;
         n_total++; if (Target !== 32'h00000210) $display("FAIL mul_target[%0d]: got %h expected 00000210", i, Target); else n_pass++;
`ifdef EXEC_OVERFLOW_FLAG_EN
         n_total++; if (Overflow !== vovf[i]) $display("FAIL mul_overflow[%0d]: got %b expected %b", i, Overflow, vovf[i]); else n_pass++;
`endif
         tick();
         n_total++; if (out_valid !== 1'b0) $display("FAIL mul_drain[%0d]: got %b expected 0", i, out_valid); else n_pass++;
         n_total++; if (ALUout !== vexp[i]) $display("FAIL mul_no_decoy[%0d]: got %h expected %h", i, ALUout, vexp[i]); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'd1, 32'd2, ADD, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      tick();
      n_total++; if (ALUout !== 32'd3) $display("FAIL bp_first: got %h expected 00000003", ALUout); else n_pass++;
      @(negedge clk);
      drive(32'd10, 32'd4, SUB, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         n_total++; if (ALUout !== 32'd3) $display("FAIL bp_hold_alu[%0d]: got %h expected 00000003", i, ALUout); else n_pass++;
         n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); else n_pass++;
         n_total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, in_ready); else n_pass++;
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready); else n_pass++;
      tick();
      n_total++; if (ALUout !== 32'd6) $display("FAIL bp_replace: got %h expected 00000006", ALUout); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_replace_valid: got %b expected 1", out_valid); else n_pass++;
      drain();
      n_total++; if (out_valid !== 1'b0) $display("FAIL bp_no_duplicate: got %b expected 0", out_valid); else n_pass++;
      n_total++; if (ALUout !== 32'd6) $display("FAIL bp_final_alu: got %h expected 00000006", ALUout); else n_pass++;
   endtask

   task automatic test_reset_mid_mul();
      logic seen;
      @(negedge clk);
      drive(32'd7, 32'd6, ADD, 1'b1, 1'b0, 1'b0, 16'd0, 32'h00000300);
      tick();
      in_valid = 1'b0;
      n_total++; if (Target !== 32'h00000300) $display("FAIL rmm_target_latched: got %h expected 00000300", Target); else n_pass++;
      repeat (10) tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if (ALUout !== 32'd0) $display("FAIL rmm_alu: got %h expected 0", ALUout); else n_pass++;
      n_total++; if (Target !== 32'd0) $display("FAIL rmm_target: got %h expected 0", Target); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rmm_valid: got %b expected 0", out_valid); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL rmm_in_ready: got %b expected 1", in_ready); else n_pass++;
      drive(32'd1, 32'd1, ADD, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      tick();
      n_total++; if (ALUout !== 32'd2) $display("FAIL rmm_add: got %h expected 00000002", ALUout); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL rmm_add_valid: got %b expected 1", out_valid); else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      seen = 1'b0;
      tick();
      repeat (40) begin
         tick();
         if (out_valid === 1'b1) seen = 1'b1;
      end
      n_total++; if (seen !== 1'b0) $display("FAIL rmm_stale_mul: got %b expected 0", seen); else n_pass++;
      n_total++; if (ALUout !== 32'd2) $display("FAIL rmm_alu_kept: got %h expected 00000002", ALUout); else n_pass++;
   endtask

   task automatic test_compare_overflow();
      logic [31:0] va   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd5, 32'h7FFFFFFF, 32'h80000000};
      logic [31:0] vb   [7] = '{32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd1, 32'd1};
      logic [2:0]  vc   [7] = '{SLT, SLTU, SLT, SLTU, SLT, ADD, SUB};
      logic [31:0] vexp [7] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'h80000000, 32'h7FFFFFFF};
`ifdef EXEC_OVERFLOW_FLAG_EN
      logic        vovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(va[i], vb[i], vc[i], 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
         tick();
         n_total++; if (ALUout !== vexp[i]) $display("FAIL cmp_result[%0d]: got %h expected %h", i, ALUout, vexp[i]); else n_pass++;
`ifdef EXEC_OVERFLOW_FLAG_EN
         n_total++; if (Overflow !== vovf[i]) $display("FAIL cmp_overflow[%0d]: got %b expected %b", i, Overflow, vovf[i]); else n_pass++;
`endif
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_target();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_compare_overflow();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
